// File: rtl/note_seq_pkg.sv
// -----------------------------------------------------------------------------
// note_seq_pkg
// Shared types and constants for the note sequencer and its tone map:
//   state_t       sequencer FSM states (IDLE / PLAY / GAP / DONE)
//   REST_PRELOAD  divider preload that silences the divider output
//   TONE_*        divider preload values for note codes 1..7
//   song_entry_t  one song table entry {code[3:0], dur[2:0]}
//   SONG_TABLE    the fixed 16-entry melody
//   eff_dur()     duration with the dur = 0 -> 1 beat rule applied
// -----------------------------------------------------------------------------
package note_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // 8'hFF keeps the divider counter parked at 255, so fout never toggles.
    localparam logic [7:0] REST_PRELOAD = 8'hFF;

    localparam logic [7:0] TONE_1 = 8'd16;
    localparam logic [7:0] TONE_2 = 8'd45;
    localparam logic [7:0] TONE_3 = 8'd70;
    localparam logic [7:0] TONE_4 = 8'd82;
    localparam logic [7:0] TONE_5 = 8'd104;
    localparam logic [7:0] TONE_6 = 8'd124;
    localparam logic [7:0] TONE_7 = 8'd141;

    typedef struct packed {
        logic [3:0] code;  // 0 and 8..15 are rests
        logic [2:0] dur;   // beats; 0 is played as 1 beat
    } song_entry_t;

    localparam int unsigned SONG_TABLE_LEN = 16;

    localparam song_entry_t SONG_TABLE [SONG_TABLE_LEN] = '{
        '{4'd1, 3'd2}, '{4'd0, 3'd1}, '{4'd7, 3'd0}, '{4'd3, 3'd1},
        '{4'd3, 3'd1}, '{4'd4, 3'd1}, '{4'd5, 3'd2}, '{4'd0, 3'd1},
        '{4'd5, 3'd1}, '{4'd4, 3'd1}, '{4'd3, 3'd1}, '{4'd2, 3'd1},
        '{4'd1, 3'd2}, '{4'd6, 3'd1}, '{4'd5, 3'd1}, '{4'd1, 3'd4}
    };

    function automatic logic [2:0] eff_dur(input logic [2:0] dur);
        return (dur == 3'd0) ? 3'd1 : dur;
    endfunction

endpackage

// File: rtl/note_seq_if.sv
// -----------------------------------------------------------------------------
// note_seq_if
// Control and output bundle of the note sequencer.
//   start / stop / loop_en  commands from the controller (master -> slave)
//   d                       preload to the divider, 8'hFF = silent
//   note_idx                song entry currently playing
//   playing                 high while in PLAY or GAP
//   done                    one-cycle pulse when a non-looping song ends
//   dbg_state               current FSM state, for observation only
// Commands are level signals sampled on every rising clk edge; there is no
// valid/ready handshake -- stop wins over start whenever both are high.
// -----------------------------------------------------------------------------
interface note_seq_if;
    import note_seq_pkg::*;

    logic       start;
    logic       stop;
    logic       loop_en;
    logic [7:0] d;
    logic [3:0] note_idx;
    logic       playing;
    logic       done;
    state_t     dbg_state;

    modport master (
        output start, stop, loop_en,
        input  d, note_idx, playing, done, dbg_state
    );

    modport slave (
        input  start, stop, loop_en,
        output d, note_idx, playing, done, dbg_state
    );

endinterface

// File: rtl/note_seq_tone_lut.sv
// -----------------------------------------------------------------------------
// tone_lut
// Purely combinational note code -> divider preload map.
//   i_code     note code, 1..7 are tones, everything else is a rest
//   o_preload  divider preload (REST_PRELOAD for rests)
// -----------------------------------------------------------------------------
module tone_lut
    import note_seq_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [7:0] o_preload
);

    always_comb begin
        o_preload = REST_PRELOAD;
        case (i_code)
            4'd1:    o_preload = TONE_1;
            4'd2:    o_preload = TONE_2;
            4'd3:    o_preload = TONE_3;
            4'd4:    o_preload = TONE_4;
            4'd5:    o_preload = TONE_5;
            4'd6:    o_preload = TONE_6;
            4'd7:    o_preload = TONE_7;
            default: o_preload = REST_PRELOAD;
        endcase
    end

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Steps through SONG_TABLE and drives the preload of an 8-bit preload
// frequency divider so that its output plays the melody. Each note lasts
// dur*BEAT_DIV clocks: the tone for all but the last GAP_CYCLES clocks,
// then silence for GAP_CYCLES clocks.
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   note_seq_if slave: start/stop/loop_en in; d, note_idx, playing,
//         done, dbg_state out (all outputs registered)
// -----------------------------------------------------------------------------
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter logic [23:0] BEAT_DIV   = 24'd6_000_000,
    parameter logic [23:0] GAP_CYCLES = 24'd600_000,
    parameter int unsigned SONG_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    note_seq_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

    state_t      r_state,   w_state_nxt;
    logic [26:0] r_cnt,     w_cnt_nxt;
    logic [3:0]  r_idx,     w_idx_nxt;
    logic [7:0]  r_d,       w_d_nxt;
    logic        r_playing, w_playing_nxt;
    logic        r_done,    w_done_nxt;

    logic [2:0]  w_cur_dur;
    logic [26:0] w_note_len;
    logic [26:0] w_play_last;
    logic [26:0] w_gap_last;
    logic        w_last_entry;
    logic        w_advance;
    logic [3:0]  w_adv_idx;
    logic [3:0]  w_adv_code;
    logic [7:0]  w_adv_tone;
    logic [3:0]  w_first_code;
    logic [7:0]  w_first_tone;

    // Note timing for the current entry. 27 bits hold 7*BEAT_DIV for any
    // 24-bit BEAT_DIV, so the product never wraps.
    assign w_cur_dur   = SONG_TABLE[r_idx].dur;
    assign w_note_len  = 27'(eff_dur(w_cur_dur)) * 27'(BEAT_DIV);
    assign w_play_last = w_note_len - 27'(GAP_CYCLES) - 27'd1;
    assign w_gap_last  = 27'(GAP_CYCLES) - 27'd1;

    // Entry that follows the current one (wraps to 0 after the last entry);
    // its tone is looked up ahead so d can switch on the advancing edge.
    assign w_last_entry = (r_idx == LAST_IDX);
    assign w_adv_idx    = w_last_entry ? 4'd0 : (r_idx + 4'd1);
    assign w_adv_code   = SONG_TABLE[w_adv_idx].code;
    assign w_first_code = SONG_TABLE[0].code;

    tone_lut u_adv_lut (
        .i_code    (w_adv_code),
        .o_preload (w_adv_tone)
    );

    tone_lut u_first_lut (
        .i_code    (w_first_code),
        .o_preload (w_first_tone)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 27'd0;
            r_idx     <= 4'd0;
            r_d       <= REST_PRELOAD;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_d       <= w_d_nxt;
            r_playing <= w_playing_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output logic. The output registers are loaded with
    // the values belonging to the state being entered, so d follows the
    // state with no extra cycle of latency.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_d_nxt       = r_d;
        w_playing_nxt = r_playing;
        w_done_nxt    = 1'b0;
        w_advance     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt     = 27'd0;
                w_d_nxt       = REST_PRELOAD;
                w_playing_nxt = 1'b0;
                if (bus.start) begin
                    w_state_nxt   = ST_PLAY;
                    w_idx_nxt     = 4'd0;
                    w_d_nxt       = w_first_tone;
                    w_playing_nxt = 1'b1;
                end
            end

            ST_PLAY: begin
                if (r_cnt == w_play_last) begin
                    if (GAP_CYCLES == 24'd0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = 27'd0;
                        w_d_nxt     = REST_PRELOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 27'd1;
                end
            end

            ST_GAP: begin
                if (r_cnt == w_gap_last) begin
                    w_advance = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 27'd1;
                end
            end

            ST_DONE: begin
                w_state_nxt   = ST_IDLE;
                w_d_nxt       = REST_PRELOAD;
                w_playing_nxt = 1'b0;
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = 27'd0;
                w_d_nxt       = REST_PRELOAD;
                w_playing_nxt = 1'b0;
            end
        endcase

        // End of a note: move to the next entry, loop, or finish.
        // loop_en only matters here, on the last entry.
        if (w_advance) begin
            w_cnt_nxt = 27'd0;
            if (!w_last_entry || bus.loop_en) begin
                w_state_nxt   = ST_PLAY;
                w_idx_nxt     = w_adv_idx;
                w_d_nxt       = w_adv_tone;
                w_playing_nxt = 1'b1;
            end else begin
                w_state_nxt   = ST_DONE;
                w_d_nxt       = REST_PRELOAD;
                w_playing_nxt = 1'b0;
                w_done_nxt    = 1'b1;
            end
        end

        // stop overrides everything, including a start in the same cycle;
        // note_idx is left holding the entry that was interrupted.
        if (bus.stop) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = 27'd0;
            w_idx_nxt     = r_idx;
            w_d_nxt       = REST_PRELOAD;
            w_playing_nxt = 1'b0;
            w_done_nxt    = 1'b0;
        end
    end

    assign bus.d         = r_d;
    assign bus.note_idx  = r_idx;
    assign bus.playing   = r_playing;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Drives note_sequencer with BEAT_DIV=4, GAP_CYCLES=1, SONG_LEN=3 over the
// first three table entries {1,2},{0,1},{7,0}. Every driven cycle pushes the
// hand-computed output vector {d, note_idx, playing, done} expected after the
// next rising edge; a monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_note_sequencer;
    import note_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    note_seq_if u_if ();

    note_sequencer #(
        .BEAT_DIV   (24'd4),
        .GAP_CYCLES (24'd1),
        .SONG_LEN   (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    localparam logic [7:0] FF  = 8'hFF;
    localparam logic [7:0] T1  = 8'd16;
    localparam logic [7:0] T7  = 8'd141;

    logic [13:0] exp_q[$];
    logic [13:0] mon_exp;
    logic [13:0] mon_act;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_cycle  = 0;
    logic        r_loop   = 1'b0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        n_cycle = n_cycle + 1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {u_if.d, u_if.note_idx, u_if.playing, u_if.done};
            n_checks = n_checks + 1;
            if (mon_act !== mon_exp) begin
                n_errors = n_errors + 1;
                $display("FAIL out_vec cycle %0d: got d=%02h idx=%0d playing=%b done=%b, expected d=%02h idx=%0d playing=%b done=%b",
                         n_cycle, mon_act[13:6], mon_act[5:2], mon_act[1], mon_act[0],
                         mon_exp[13:6], mon_exp[5:2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs and queue the outputs expected after the
    // following rising edge.
    task automatic cyc(input logic st, input logic sp, input logic rs,
                       input logic [7:0] ed, input logic [3:0] ei,
                       input logic ep, input logic edn);
        @(negedge clk);
        #1;
        u_if.start   = st;
        u_if.stop    = sp;
        u_if.loop_en = r_loop;
        rst          = rs;
        exp_q.push_back({ed, ei, ep, edn});
    endtask

    task automatic seg(input logic st, input logic [7:0] ed, input logic [3:0] ei,
                       input logic ep, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(st, 1'b0, 1'b0, ed, ei, ep, 1'b0);
        end
    endtask

    // Rest of one pass through the song after the cycle that showed the
    // first d=16: 6 more tone clocks, gap, rest entry, 141 entry, gap.
    task automatic song_body(input logic st);
        seg(st, T1, 4'd0, 1'b1, 6);
        seg(st, FF, 4'd0, 1'b1, 1);
        seg(st, FF, 4'd1, 1'b1, 4);
        seg(st, T7, 4'd2, 1'b1, 3);
        seg(st, FF, 4'd2, 1'b1, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        u_if.start   = 1'b0;
        u_if.stop    = 1'b0;
        u_if.loop_en = 1'b0;
        rst          = 1'b1;

        // Reset state, held in IDLE afterwards.
        cyc(1'b0, 1'b0, 1'b1, FF, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, FF, 4'd0, 1'b0, 1'b0);
        seg(1'b0, FF, 4'd0, 1'b0, 2);

        // Reference run, loop_en = 0: done pulse then IDLE.
        cyc(1'b1, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        song_body(1'b0);
        cyc(1'b0, 1'b0, 1'b0, FF, 4'd2, 1'b0, 1'b1);
        seg(1'b0, FF, 4'd2, 1'b0, 2);

        // start held high throughout: ignored while playing, identical
        // timing; after DONE->IDLE it starts playback again.
        cyc(1'b1, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        song_body(1'b1);
        cyc(1'b1, 1'b0, 1'b0, FF, 4'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, FF, 4'd2, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, FF, 4'd0, 1'b0, 1'b0);
        seg(1'b0, FF, 4'd0, 1'b0, 1);

        // Looping: two full passes, then the third begins with no done pulse.
        r_loop = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        song_body(1'b0);
        cyc(1'b0, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        song_body(1'b0);
        cyc(1'b0, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        seg(1'b0, T1, 4'd0, 1'b1, 1);
        cyc(1'b0, 1'b1, 1'b0, FF, 4'd0, 1'b0, 1'b0);
        r_loop = 1'b0;
        seg(1'b0, FF, 4'd0, 1'b0, 1);

        // stop in the third PLAY cycle of entry 0, then start+stop in IDLE.
        cyc(1'b1, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        seg(1'b0, T1, 4'd0, 1'b1, 2);
        cyc(1'b0, 1'b1, 1'b0, FF, 4'd0, 1'b0, 1'b0);
        seg(1'b0, FF, 4'd0, 1'b0, 2);
        cyc(1'b1, 1'b1, 1'b0, FF, 4'd0, 1'b0, 1'b0);
        seg(1'b0, FF, 4'd0, 1'b0, 2);

        // rst during the GAP of entry 1, then a fresh start from entry 0.
        cyc(1'b1, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        seg(1'b0, T1, 4'd0, 1'b1, 6);
        seg(1'b0, FF, 4'd0, 1'b1, 1);
        seg(1'b0, FF, 4'd1, 1'b1, 3);
        cyc(1'b0, 1'b0, 1'b0, FF, 4'd1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, FF, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, FF, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, T1, 4'd0, 1'b1, 1'b0);
        seg(1'b0, T1, 4'd0, 1'b1, 2);
        cyc(1'b0, 1'b1, 1'b0, FF, 4'd0, 1'b0, 1'b0);
        seg(1'b0, FF, 4'd0, 1'b0, 1);

        // Every queued expectation must have been consumed.
        repeat (3) @(negedge clk);
        #2;
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
